pc_sequencer: RTL and testbench

Instruction-sequencing controller for the 8-bit processor core. Owns the program counter register, drives the instruction-memory fetch handshake, hands each fetched instruction to decode, then waits for execute to resolve the control-flow outcome and computes the next PC (sequential, absolute/relative jump, conditional branch, register jump). It sits between instruction memory, decode and the execute-stage branch resolution, and sequences the next-PC datapath with one instruction in flight.

---
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter owner and fetch/issue/resolve sequencer, one instruction in flight
// Ports: system1000 clock, system1000_rstn sync active-low reset;
//   fetch_req/fetch_addr/fetch_ack/fetch_instr  instruction-memory handshake (fetch_addr is the PC);
//   instr_valid/instr_out/pc_out/dec_ready      issue handshake to decode;
//   br_valid/br_kind/br_cond/br_off/br_target   control-flow outcome from execute;
//   halt/halted                                 stop at next instruction boundary, leave only by reset;
//   ras_err                                     sticky return-address-stack under/overflow.
// Optional feature: define PC_SEQUENCER_RAS_EN for the call/return stack (kinds 6/7).
module pc_sequencer #(
  parameter int PC_W = 8,
  parameter int INSTR_W = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                      system1000,
  input  logic                      system1000_rstn,
  output logic                      fetch_req,
  output logic [PC_W-1:0]           fetch_addr,
  input  logic                      fetch_ack,
  input  logic [INSTR_W-1:0]        fetch_instr,
  output logic                      instr_valid,
  output logic [INSTR_W-1:0]        instr_out,
  output logic [PC_W-1:0]           pc_out,
  input  logic                      dec_ready,
  input  logic                      br_valid,
  input  logic [2:0]                br_kind,
  input  logic                      br_cond,
  input  logic signed [PC_W-1:0]    br_off,
  input  logic signed [15:0]        br_target,
  input  logic                      halt,
  output logic                      halted,
  output logic                      ras_err
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESOLVE, S_HALT} state_t;
  state_t r_state;
  logic [PC_W-1:0] r_pc, r_pc_out, w_seq, w_rel, w_next;
  logic [INSTR_W-1:0] r_instr;
  logic r_fetch_req, r_instr_valid, r_halted, r_halt_pending;
  logic w_unused;
  assign w_seq = r_pc + PC_W'(1);
  assign w_rel = r_pc + br_off;
  assign w_unused = ^br_target ^ (RAS_DEPTH > 0);
`ifdef PC_SEQUENCER_RAS_EN
  localparam int SP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  // Circular stack: r_sp is the next free slot, so a push when full lands on the oldest entry.
  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [SP_W-1:0] r_sp, w_sp_inc, w_sp_dec;
  logic [SP_W:0] r_cnt;
  logic r_ras_err, w_full, w_empty;
  assign w_sp_inc = (r_sp == SP_W'(RAS_DEPTH - 1)) ? '0 : r_sp + SP_W'(1);
  assign w_sp_dec = (r_sp == '0) ? SP_W'(RAS_DEPTH - 1) : r_sp - SP_W'(1);
  assign w_full = r_cnt == (SP_W + 1)'(RAS_DEPTH);
  assign w_empty = r_cnt == '0;
  assign ras_err = r_ras_err;
`else
  assign ras_err = 1'b0;
`endif
  always_comb begin
    w_next = w_seq;
    case (br_kind)
      3'd1: w_next = br_off;
      3'd2: w_next = w_rel;
      3'd3: w_next = br_cond ? br_off : w_seq;
      3'd4: w_next = br_cond ? w_rel : w_seq;
      3'd5: w_next = br_target[PC_W-1:0];
`ifdef PC_SEQUENCER_RAS_EN
      3'd6: w_next = br_off;
      3'd7: w_next = w_empty ? w_seq : r_ras[w_sp_dec];
`endif
      default: w_next = w_seq;
    endcase
  end
  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      r_state <= S_IDLE;
      r_pc <= '0;
      r_pc_out <= '0;
      r_instr <= '0;
      r_fetch_req <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted <= 1'b0;
      r_halt_pending <= 1'b0;
`ifdef PC_SEQUENCER_RAS_EN
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      r_sp <= '0;
      r_cnt <= '0;
      r_ras_err <= 1'b0;
`endif
    end else begin
      r_halt_pending <= r_halt_pending | halt;
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
          r_fetch_req <= 1'b1;
        end
        S_FETCH: if (fetch_ack) begin
          r_instr <= fetch_instr;
          r_pc_out <= r_pc;
          r_fetch_req <= 1'b0;
          r_instr_valid <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: if (dec_ready) begin
          r_instr_valid <= 1'b0;
          r_state <= S_RESOLVE;
        end
        S_RESOLVE: if (br_valid) begin
          r_pc <= w_next;
          // A halt seen at any point up to and including this cycle stops at this boundary.
          if (r_halt_pending | halt) begin
            r_state <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_fetch_req <= 1'b1;
          end
`ifdef PC_SEQUENCER_RAS_EN
          if (br_kind == 3'd6) begin
            r_ras[r_sp] <= w_seq;
            r_sp <= w_sp_inc;
            if (w_full) r_ras_err <= 1'b1;
            else r_cnt <= r_cnt + (SP_W + 1)'(1);
          end else if (br_kind == 3'd7) begin
            if (w_empty) r_ras_err <= 1'b1;
            else begin
              r_sp <= w_sp_dec;
              r_cnt <= r_cnt - (SP_W + 1)'(1);
            end
          end
`endif
        end
        default: r_state <= r_state;
      endcase
    end
  end
  assign fetch_req = r_fetch_req;
  assign fetch_addr = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_out = r_instr;
  assign pc_out = r_pc_out;
  assign halted = r_halted;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: vector table, hand sequences and random instructions against a queue-based next-PC model
module tb_pc_sequencer;
  localparam int PC_W = 8;
  localparam int INSTR_W = 16;
  localparam int RAS_DEPTH = 4;
  logic system1000 = 1'b0;
  logic system1000_rstn = 1'b0;
  logic fetch_req, instr_valid, halted, ras_err;
  logic [PC_W-1:0] fetch_addr, pc_out;
  logic [INSTR_W-1:0] instr_out;
  logic fetch_ack = 1'b0, dec_ready = 1'b0, br_valid = 1'b0, br_cond = 1'b0, halt = 1'b0;
  logic [INSTR_W-1:0] fetch_instr = '0;
  logic [2:0] br_kind = '0;
  logic signed [PC_W-1:0] br_off = '0;
  logic signed [15:0] br_target = '0;
  int n_chk = 0, n_err = 0;
  logic [7:0] m_pc;
  logic [7:0] m_ras[$];
  logic m_err, m_halt;
  typedef struct {
    logic [7:0] pc0;
    logic [2:0] k;
    logic c;
    logic [7:0] off;
    logic [15:0] tgt;
    logic [7:0] exp;
  } vec_t;
  vec_t vt[11];

  pc_sequencer #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .system1000(system1000), .system1000_rstn(system1000_rstn),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .instr_valid(instr_valid), .instr_out(instr_out), .pc_out(pc_out), .dec_ready(dec_ready),
    .br_valid(br_valid), .br_kind(br_kind), .br_cond(br_cond), .br_off(br_off), .br_target(br_target),
    .halt(halt), .halted(halted), .ras_err(ras_err)
  );

  always #5 system1000 = ~system1000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge system1000);
    #1;
  endtask

  // Next PC from the control-flow rules, in plain integer arithmetic mod 256.
  task automatic model_step(input logic [2:0] k, input logic c, input logic [7:0] off, input logic [15:0] tgt);
    int p, o, seq, rel, nx;
    p = int'(m_pc);
    o = int'($signed(off));
    seq = (p + 1) % 256;
    rel = (p + o + 256) % 256;
    nx = seq;
    case (k)
      3'd1: nx = int'(off);
      3'd2: nx = rel;
      3'd3: nx = c ? int'(off) : seq;
      3'd4: nx = c ? rel : seq;
      3'd5: nx = int'(tgt) % 256;
`ifdef PC_SEQUENCER_RAS_EN
      3'd6: begin
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_err = 1'b1;
        end
        m_ras.push_back(8'(seq));
        nx = int'(off);
      end
      3'd7: begin
        if (m_ras.size() == 0) m_err = 1'b1;
        else nx = int'(m_ras.pop_back());
      end
`endif
      default: nx = seq;
    endcase
    m_pc = 8'(nx);
  endtask

  task automatic do_reset();
    system1000_rstn = 1'b0;
    fetch_ack = 1'b0;
    dec_ready = 1'b0;
    br_valid = 1'b0;
    halt = 1'b0;
    repeat (2) tick();
    chk("reset_ctl", {fetch_req, instr_valid, halted, ras_err, fetch_addr, pc_out}, '0);
    chk("reset_instr", instr_out, '0);
    system1000_rstn = 1'b1;
    tick();
    chk("first_fetch", {fetch_req, fetch_addr}, {1'b1, 8'h00});
    m_pc = '0;
    m_ras.delete();
    m_err = 1'b0;
    m_halt = 1'b0;
  endtask

  // One full instruction from FETCH, with ad/rd/bd stall cycles before ack/ready/br_valid.
  task automatic run_instr(input logic [2:0] k, input logic c, input logic [7:0] off, input logic [15:0] tgt,
                           input int ad, input int rd, input int bd, input logic hr);
    logic [15:0] ins;
    ins = 16'($urandom);
    chk("fetch_start", {fetch_req, instr_valid, fetch_addr}, {2'b10, m_pc});
    for (int i = 0; i < ad; i++) begin
      tick();
      chk("fetch_hold", {fetch_req, instr_valid, fetch_addr}, {2'b10, m_pc});
    end
    fetch_ack = 1'b1;
    fetch_instr = ins;
    tick();
    fetch_ack = 1'b0;
    fetch_instr = 16'($urandom);
    chk("issue", {fetch_req, instr_valid, instr_out, pc_out}, {2'b01, ins, m_pc});
    for (int i = 0; i < rd; i++) begin
      tick();
      chk("issue_hold", {fetch_req, instr_valid, instr_out, pc_out}, {2'b01, ins, m_pc});
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    chk("resolve_wait", {fetch_req, instr_valid}, 2'b00);
    for (int i = 0; i < bd; i++) begin
      tick();
      chk("resolve_hold", {fetch_req, instr_valid, fetch_addr}, {2'b00, m_pc});
    end
    br_valid = 1'b1;
    br_kind = k;
    br_cond = c;
    br_off = off;
    br_target = tgt;
    halt = hr;
    tick();
    br_valid = 1'b0;
    halt = 1'b0;
    br_kind = 3'($urandom);
    br_off = 8'($urandom);
    model_step(k, c, off, tgt);
    if (hr) m_halt = 1'b1;
    chk("next_pc", fetch_addr, m_pc);
    chk("after_resolve", {fetch_req, halted, ras_err}, {~m_halt, m_halt, m_err});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{8'h10, 3'd2, 1'b0, 8'hFD, 16'h0000, 8'h0D};
    vt[1]  = '{8'hFE, 3'd2, 1'b0, 8'h05, 16'h0000, 8'h03};
    vt[2]  = '{8'h20, 3'd3, 1'b0, 8'h40, 16'h0000, 8'h21};
    vt[3]  = '{8'h20, 3'd4, 1'b0, 8'h40, 16'h0000, 8'h21};
    vt[4]  = '{8'h20, 3'd3, 1'b1, 8'h40, 16'h0000, 8'h40};
    vt[5]  = '{8'h20, 3'd4, 1'b1, 8'h40, 16'h0000, 8'h60};
    vt[6]  = '{8'h20, 3'd5, 1'b0, 8'h00, 16'h1234, 8'h34};
    vt[7]  = '{8'h7F, 3'd1, 1'b0, 8'h80, 16'h0000, 8'h80};
    vt[8]  = '{8'hFF, 3'd0, 1'b1, 8'h33, 16'h0000, 8'h00};
    vt[9]  = '{8'h80, 3'd4, 1'b1, 8'h80, 16'h0000, 8'h00};
    vt[10] = '{8'h40, 3'd5, 1'b1, 8'h11, 16'hFFAB, 8'hAB};
    do_reset();
    fetch_ack = 1'b1;
    dec_ready = 1'b1;
    br_valid = 1'b1;
    br_kind = 3'd0;
    for (int t = 1; t <= 9; t++) begin
      tick();
      chk("stream", {fetch_req, fetch_addr}, {(t % 3 == 0), 8'(t / 3)});
    end
    fetch_ack = 1'b0;
    dec_ready = 1'b0;
    br_valid = 1'b0;
    m_pc = 8'h03;
    for (int i = 0; i < 11; i++) begin
      run_instr(3'd1, 1'b0, vt[i].pc0, 16'h0, 0, 0, 0, 1'b0);
      run_instr(vt[i].k, vt[i].c, vt[i].off, vt[i].tgt, 0, 0, 0, 1'b0);
      chk("vec_pc", fetch_addr, vt[i].exp);
    end
    run_instr(3'd0, 1'b0, 8'h00, 16'h0, 4, 2, 0, 1'b0);
    for (int i = 0; i < 40; i++)
      run_instr(3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom), 16'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
`ifdef PC_SEQUENCER_RAS_EN
    do_reset();
    run_instr(3'd1, 1'b0, 8'h05, 16'h0, 0, 0, 0, 1'b0);
    run_instr(3'd6, 1'b0, 8'h30, 16'h0, 0, 0, 0, 1'b0);
    chk("call_tgt", fetch_addr, 8'h30);
    run_instr(3'd7, 1'b0, 8'h00, 16'h0, 0, 0, 0, 1'b0);
    chk("ret_tgt", {ras_err, fetch_addr}, {1'b0, 8'h06});
    for (int i = 0; i < 5; i++) run_instr(3'd6, 1'b0, 8'(8'h40 + i), 16'h0, 0, 0, 0, 1'b0);
    run_instr(3'd7, 1'b0, 8'h00, 16'h0, 0, 0, 0, 1'b0);
    chk("ras_ovf", {ras_err, fetch_addr}, {1'b1, 8'h44});
    do_reset();
    run_instr(3'd1, 1'b0, 8'h50, 16'h0, 0, 0, 0, 1'b0);
    run_instr(3'd7, 1'b0, 8'h00, 16'h0, 0, 0, 0, 1'b0);
    chk("ras_unf", {ras_err, fetch_addr}, {1'b1, 8'h51});
`else
    do_reset();
    run_instr(3'd1, 1'b0, 8'h05, 16'h0, 0, 0, 0, 1'b0);
    run_instr(3'd6, 1'b0, 8'h30, 16'h0, 0, 0, 0, 1'b0);
    chk("call_noras", {ras_err, fetch_addr}, {1'b0, 8'h06});
    run_instr(3'd7, 1'b0, 8'h30, 16'h0, 0, 0, 0, 1'b0);
    chk("ret_noras", {ras_err, fetch_addr}, {1'b0, 8'h07});
`endif
    do_reset();
    run_instr(3'd1, 1'b0, 8'h10, 16'h0, 0, 0, 0, 1'b0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_pulse", {fetch_req, halted}, 2'b10);
    m_halt = 1'b1;
    run_instr(3'd2, 1'b0, 8'h04, 16'h0, 1, 0, 1, 1'b0);
    chk("halt_pc", fetch_addr, 8'h14);
    fetch_ack = 1'b1;
    dec_ready = 1'b1;
    br_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_stay", {fetch_req, instr_valid, halted, fetch_addr}, {3'b001, 8'h14});
    end
    do_reset();
    run_instr(3'd1, 1'b0, 8'h22, 16'h0, 0, 0, 0, 1'b1);
    chk("halt_resolve", {fetch_req, halted, fetch_addr}, {2'b01, 8'h22});
    do_reset();
    fetch_ack = 1'b1;
    fetch_instr = 16'hBEEF;
    tick();
    chk("pre_reset_issue", {instr_valid, instr_out}, {1'b1, 16'hBEEF});
    system1000_rstn = 1'b0;
    tick();
    chk("mid_reset_ctl", {fetch_req, instr_valid, halted, ras_err, fetch_addr, pc_out}, '0);
    chk("mid_reset_instr", instr_out, '0);
    tick();
    chk("mid_reset_hold", {fetch_req, instr_valid, instr_out}, '0);
    fetch_ack = 1'b0;
    do_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
